param_accumulator: RTL and testbench
====================================

# param_accumulator

Parametrised successor to the 4-bit step accumulator: a WIDTH-bit registered accumulator that adds, subtracts or loads a step value each enabled cycle. It has optional saturation, a sticky overflow flag and a one-cycle limit-crossing pulse. It sits beside the ALU datapath as a general counting/accumulation element. It replaces the fixed add-only, 4-bit, level-reset accumulator with clean edge-triggered behaviour.

## Interface
Parameters:
- WIDTH, 4, datapath width of step, limit and Yo (WIDTH ≥ 2).
- SATURATE, 0, 0 = modulo 2^WIDTH wrap; 1 = clamp at 2^WIDTH−1 (add) and 0 (sub).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; reset==0 forces all state to reset values immediately.
- en  input  1  operation enable; op is applied only when en=1.
- op  input  2  00 add, 01 subtract, 10 load, 11 hold.
- clr  input  1  synchronous clear, overrides en/op.
- step  input  WIDTH  operand for add/sub/load.
- limit  input  WIDTH  threshold for hit detection (unsigned).
- Yo  output  WIDTH  accumulator value (registered).
- ovf  output  1  sticky overflow/underflow flag (registered).
- hit  output  1  one-cycle pulse on upward crossing of limit (registered).

## Operation
- All arithmetic is unsigned, WIDTH bits. Internal sum/difference uses WIDTH+1 bits to detect carry or borrow.
- Per rising edge, priority: clr > en > hold.
  - clr=1: Yo←0, ovf←0, hit←0.
  - en=1, op=00: raw = Yo + step. On carry out, set ovf. Yo←2^WIDTH−1 if SATURATE else raw mod 2^WIDTH.
  - en=1, op=01: raw = Yo − step. On borrow (step > Yo), set ovf. Yo←0 if SATURATE else raw mod 2^WIDTH.
  - en=1, op=10: Yo←step. ovf unchanged.
  - en=1, op=11, or en=0: Yo and ovf unchanged.
- ovf is sticky. It is cleared only by reset or clr.
- hit: let ge_now = (Yo ≥ limit) and ge_next = (Yo_next ≥ limit).
  - hit←1 when not clr and ge_now=0 and ge_next=1; else hit←0.
  - A load that crosses the limit also pulses hit.
  - A limit change that makes the compare true without a Yo update does not pulse hit, since Yo_next = Yo.
- limit=0: Yo ≥ 0 is always true, so hit never pulses.
- Wrap mode, add that wraps below limit: no pulse. It pulses again when the value next climbs to ≥ limit.

## Timing
- Reset values: Yo=0, ovf=0, hit=0. They take effect asynchronously on reset falling. Release is synchronous to the next rising edge.
- Latency: Yo, ovf and hit reflect an operation one cycle after the edge where en/op/step/clr are sampled.
- hit is a single-cycle pulse. Back-to-back crossings, e.g. load below limit then add above, each pulse independently.
- Reset asserted mid-sequence: all state returns to reset values; no pending operation survives.
- clr and en together: clr wins; step is ignored that cycle.
- Inputs must be stable around the rising edge. No combinational path from inputs to outputs.

## Test plan
- WIDTH=4, SATURATE=0: reset released, en=1, op=00, step=1 for 17 cycles → Yo counts 1..15, then 0. ovf=1 from the wrap cycle onward. With limit=8, hit pulses exactly once, the cycle Yo becomes 8.
- WIDTH=4, SATURATE=1: load 14, then add 3 → Yo=15, ovf=1. Subtract 9 → Yo=6. Subtract 7 → Yo=0, ovf stays 1.
- clr and en=1/op=00/step=5 asserted in the same cycle with Yo=9, ovf=1 → next cycle Yo=0, ovf=0, hit=0.
- limit=10: load 3, add 7 → hit pulses on the Yo=10 cycle. Hold 3 cycles → hit stays 0. Load 12 → no pulse (already ≥). Load 2, then load 11 → pulse.
- Assert reset (low) asynchronously mid-cycle with Yo=13, ovf=1 → Yo, ovf and hit go to 0 before the next clock edge and remain 0 while reset is low. Operations resume on the first edge after release.
- WIDTH=8, SATURATE=0: Yo=0x05, subtract 0x06 → Yo=0xFF, ovf=1. en=0 with op=00 → Yo holds 0xFF.

Source files
------------

// File: rtl/param_accumulator_if.sv
// Operand/result bundle for param_accumulator: control and step in, value and flags out.
interface param_accumulator_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       op;
  logic             clr;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] Yo;
  logic             ovf;
  logic             hit;

  modport master (output en, op, clr, step, limit, input  Yo, ovf, hit);
  modport slave  (input  en, op, clr, step, limit, output Yo, ovf, hit);
endinterface

// File: rtl/param_accumulator.sv
// WIDTH-bit registered accumulator: add/subtract/load a step with optional saturation,
// sticky overflow flag and a one-cycle pulse when the value crosses limit upward.
module param_accumulator #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               reset,
  param_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_HOLD = 2'b11
  } op_e;

  logic [WIDTH-1:0] yo_q, yo_next;
  logic             ovf_q, ovf_next;
  logic             hit_q, hit_next;
  logic [WIDTH:0]   raw;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    yo_next  = yo_q;
    ovf_next = ovf_q;
    raw      = '0;
    if (bus.en) begin
      case (op_e'(bus.op))
        OP_ADD: begin
          raw = {1'b0, yo_q} + {1'b0, bus.step};
          if (raw[WIDTH]) begin
            ovf_next = 1'b1;
            yo_next  = (SATURATE != 0) ? '1 : raw[WIDTH-1:0];
          end else begin
            yo_next  = raw[WIDTH-1:0];
          end
        end
        OP_SUB: begin
          // Top bit of the widened difference is the borrow out.
          raw = {1'b0, yo_q} - {1'b0, bus.step};
          if (raw[WIDTH]) begin
            ovf_next = 1'b1;
            yo_next  = (SATURATE != 0) ? '0 : raw[WIDTH-1:0];
          end else begin
            yo_next  = raw[WIDTH-1:0];
          end
        end
        OP_LOAD: yo_next = bus.step;
        default: ;
      endcase
    end
    // Pulse only when the accumulator itself moves across limit; a limit change alone never does.
    hit_next = (yo_q < bus.limit) && (yo_next >= bus.limit);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      yo_q  <= '0;
      ovf_q <= 1'b0;
      hit_q <= 1'b0;
    end else if (bus.clr) begin
      yo_q  <= '0;
      ovf_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      yo_q  <= yo_next;
      ovf_q <= ovf_next;
      hit_q <= hit_next;
    end
  end

  assign bus.Yo  = yo_q;
  assign bus.ovf = ovf_q;
  assign bus.hit = hit_q;

endmodule

// File: tb/tb_param_accumulator.sv
// Directed bench for param_accumulator: wrap, saturate and 8-bit instances on one clock/reset.
module tb_param_accumulator;

  logic clk;
  logic reset;

  param_accumulator_if #(.WIDTH(4)) a4 ();
  param_accumulator_if #(.WIDTH(4)) s4 ();
  param_accumulator_if #(.WIDTH(8)) b8 ();

  param_accumulator #(.WIDTH(4), .SATURATE(0)) u_wrap4 (.clk(clk), .reset(reset), .bus(a4));
  param_accumulator #(.WIDTH(4), .SATURATE(1)) u_sat4  (.clk(clk), .reset(reset), .bus(s4));
  param_accumulator #(.WIDTH(8), .SATURATE(0)) u_wrap8 (.clk(clk), .reset(reset), .bus(b8));

  int n_total = 0;
  int n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic [1:0] op, input logic clr, input logic [3:0] step);
    a4.en = en; a4.op = op; a4.clr = clr; a4.step = step;
  endtask

  task automatic drive_s(input logic en, input logic [1:0] op, input logic [3:0] step);
    s4.en = en; s4.op = op; s4.clr = 1'b0; s4.step = step;
  endtask

  task automatic drive_b(input logic en, input logic [1:0] op, input logic [7:0] step);
    b8.en = en; b8.op = op; b8.clr = 1'b0; b8.step = step;
  endtask

  initial begin
    reset = 1'b0;
    drive_a(1'b0, 2'b11, 1'b0, 4'd0); a4.limit = 4'd8;
    drive_s(1'b0, 2'b11, 4'd0);       s4.limit = 4'd0;
    drive_b(1'b0, 2'b11, 8'd0);       b8.limit = 8'h80;

    // Reset values while reset is held low
    #2;
    check("rst_yo",  32'(a4.Yo),  32'd0);
    check("rst_ovf", 32'(a4.ovf), 32'd0);
    check("rst_hit", 32'(a4.hit), 32'd0);
    #10;
    reset = 1'b1;

    // Wrap mode count: 1..15 then 0, ovf from wrap, single hit at Yo=8
    drive_a(1'b1, 2'b00, 1'b0, 4'd1);
    for (int i = 1; i <= 17; i++) begin
      cycle();
      check($sformatf("cnt_yo_%0d", i),  32'(a4.Yo),  32'(i % 16));
      check($sformatf("cnt_ovf_%0d", i), 32'(a4.ovf), (i >= 16) ? 32'd1 : 32'd0);
      check($sformatf("cnt_hit_%0d", i), 32'(a4.hit), (i == 8) ? 32'd1 : 32'd0);
    end

    // Saturating instance, limit=0 so hit must never pulse
    drive_s(1'b1, 2'b10, 4'd14); cycle();
    check("sat_ld_yo",  32'(s4.Yo),  32'd14);
    check("sat_ld_ovf", 32'(s4.ovf), 32'd0);
    check("sat_ld_hit", 32'(s4.hit), 32'd0);
    drive_s(1'b1, 2'b00, 4'd3);  cycle();
    check("sat_add_yo",  32'(s4.Yo),  32'd15);
    check("sat_add_ovf", 32'(s4.ovf), 32'd1);
    drive_s(1'b1, 2'b01, 4'd9);  cycle();
    check("sat_sub9_yo", 32'(s4.Yo),  32'd6);
    drive_s(1'b1, 2'b01, 4'd7);  cycle();
    check("sat_sub7_yo",  32'(s4.Yo),  32'd0);
    check("sat_sub7_ovf", 32'(s4.ovf), 32'd1);
    check("sat_sub7_hit", 32'(s4.hit), 32'd0);
    drive_s(1'b0, 2'b11, 4'd0);

    // clr beats en: Yo=9, ovf=1 (sticky from the wrap above)
    drive_a(1'b1, 2'b10, 1'b0, 4'd9); cycle();
    check("pre_clr_yo",  32'(a4.Yo),  32'd9);
    check("pre_clr_ovf", 32'(a4.ovf), 32'd1);
    check("ld_cross_hit", 32'(a4.hit), 32'd1);
    drive_a(1'b1, 2'b00, 1'b1, 4'd5); cycle();
    check("clr_yo",  32'(a4.Yo),  32'd0);
    check("clr_ovf", 32'(a4.ovf), 32'd0);
    check("clr_hit", 32'(a4.hit), 32'd0);

    // limit=10 crossing sequence
    a4.limit = 4'd10;
    drive_a(1'b1, 2'b10, 1'b0, 4'd3);  cycle();
    check("l10_ld3_hit", 32'(a4.hit), 32'd0);
    drive_a(1'b1, 2'b00, 1'b0, 4'd7);  cycle();
    check("l10_add7_yo",  32'(a4.Yo),  32'd10);
    check("l10_add7_hit", 32'(a4.hit), 32'd1);
    drive_a(1'b1, 2'b11, 1'b0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("l10_hold_hit_%0d", i), 32'(a4.hit), 32'd0);
      check($sformatf("l10_hold_yo_%0d", i),  32'(a4.Yo),  32'd10);
    end
    drive_a(1'b1, 2'b10, 1'b0, 4'd12); cycle();
    check("l10_ld12_hit", 32'(a4.hit), 32'd0);
    drive_a(1'b1, 2'b10, 1'b0, 4'd2);  cycle();
    check("l10_ld2_hit", 32'(a4.hit), 32'd0);
    // Limit dropping below Yo with no update must not pulse
    a4.limit = 4'd1;
    drive_a(1'b0, 2'b00, 1'b0, 4'd0);  cycle();
    check("lim_chg_hit", 32'(a4.hit), 32'd0);
    a4.limit = 4'd10;
    drive_a(1'b1, 2'b10, 1'b0, 4'd11); cycle();
    check("l10_ld11_yo",  32'(a4.Yo),  32'd11);
    check("l10_ld11_hit", 32'(a4.hit), 32'd1);

    // Async reset mid-cycle with Yo=13, ovf=1
    drive_a(1'b1, 2'b10, 1'b0, 4'd15); cycle();
    drive_a(1'b1, 2'b00, 1'b0, 4'd14); cycle();
    check("pre_rst_yo",  32'(a4.Yo),  32'd13);
    check("pre_rst_ovf", 32'(a4.ovf), 32'd1);
    drive_a(1'b1, 2'b00, 1'b0, 4'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_yo",  32'(a4.Yo),  32'd0);
    check("async_rst_ovf", 32'(a4.ovf), 32'd0);
    check("async_rst_hit", 32'(a4.hit), 32'd0);
    cycle();
    check("rst_held_yo",  32'(a4.Yo),  32'd0);
    check("rst_held_ovf", 32'(a4.ovf), 32'd0);
    #3;
    reset = 1'b1;
    cycle();
    check("post_rst_yo",  32'(a4.Yo),  32'd1);
    check("post_rst_ovf", 32'(a4.ovf), 32'd0);
    drive_a(1'b0, 2'b11, 1'b0, 4'd0);

    // 8-bit wrap: 0x05 - 0x06 = 0xFF with borrow, then en=0 holds
    drive_b(1'b1, 2'b10, 8'h05); cycle();
    check("w8_ld_yo",  32'(b8.Yo),  32'h05);
    check("w8_ld_hit", 32'(b8.hit), 32'd0);
    drive_b(1'b1, 2'b01, 8'h06); cycle();
    check("w8_sub_yo",  32'(b8.Yo),  32'hFF);
    check("w8_sub_ovf", 32'(b8.ovf), 32'd1);
    check("w8_sub_hit", 32'(b8.hit), 32'd1);
    drive_b(1'b0, 2'b00, 8'h06);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check($sformatf("w8_hold_yo_%0d", i),  32'(b8.Yo),  32'hFF);
      check($sformatf("w8_hold_hit_%0d", i), 32'(b8.hit), 32'd0);
    end
    check("w8_hold_ovf", 32'(b8.ovf), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
